// File: rtl/operand_isolation_adder_pkg.sv
// operand_isolation_adder_pkg: shared constants for the operand-isolated adder slice.
package operand_isolation_adder_pkg;
    localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/operand_isolation_adder_if.sv
// operand_isolation_adder_if: operand/enable inputs and registered result outputs of the adder.
interface operand_isolation_adder_if
    import operand_isolation_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             enable_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             sum_valid_o;

    modport master (
        output enable_i, a_i, b_i,
        input  sum_o, cout_o, sum_valid_o
    );

    modport slave (
        input  enable_i, a_i, b_i,
        output sum_o, cout_o, sum_valid_o
    );
endinterface

// File: rtl/operand_iso_gate.sv
// operand_iso_gate: AND-gates one operand with enable so a disabled adder sees constant zero.
module operand_iso_gate #(
    parameter int WIDTH = 8
) (
    input  logic             enable_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    assign q_o = d_i & {WIDTH{enable_i}};
endmodule

// File: rtl/operand_isolation_adder.sv
// operand_isolation_adder: registered WIDTH-bit add whose operands are isolated while disabled.
module operand_isolation_adder
    import operand_isolation_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    operand_isolation_adder_if.slave  bus
);
    logic [WIDTH-1:0] a_iso;
    logic [WIDTH-1:0] b_iso;
    logic [WIDTH:0]   sum_n;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             valid_d, valid_q;

    operand_iso_gate #(.WIDTH(WIDTH)) u_iso_a (
        .enable_i (bus.enable_i),
        .d_i      (bus.a_i),
        .q_o      (a_iso)
    );

    operand_iso_gate #(.WIDTH(WIDTH)) u_iso_b (
        .enable_i (bus.enable_i),
        .d_i      (bus.b_i),
        .q_o      (b_iso)
    );

    assign sum_n = {1'b0, a_iso} + {1'b0, b_iso};

    // Result register loads only on enabled cycles; valid marks the cycle after.
    always_comb begin
        sum_d   = bus.enable_i ? sum_n[WIDTH-1:0] : sum_q;
        cout_d  = bus.enable_i ? sum_n[WIDTH] : cout_q;
        valid_d = bus.enable_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign bus.sum_o       = sum_q;
    assign bus.cout_o      = cout_q;
    assign bus.sum_valid_o = valid_q;
endmodule

// File: tb/tb_operand_isolation_adder.sv
// tb_operand_isolation_adder: scoreboard bench with directed and random stimulus against a plain-arithmetic model.
module tb_operand_isolation_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    operand_isolation_adder_if #(.WIDTH(8)) bus ();
    operand_isolation_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];
    int m_sum = 0;
    int m_cout = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {6'b0, bus.sum_valid_o, bus.cout_o, bus.sum_o};
    endfunction

    // Model: an enabled cycle yields (a+b) as a 9-bit value; a disabled one leaves it unchanged.
    task automatic drive(input bit en, input int a, input int b);
        int s;
        @(negedge clk);
        bus.enable_i = en;
        bus.a_i = a[7:0];
        bus.b_i = b[7:0];
        if (en) begin
            s = a + b;
            m_sum = s % 256;
            m_cout = s / 256;
        end
        exp_q.push_back({en, m_cout[0], m_sum[7:0]});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) check("scoreboard", outs(), {6'b0, exp_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.enable_i = 1'b0;
        bus.a_i = 8'h00;
        bus.b_i = 8'h00;
        #12;
        check("reset_state", outs(), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        // Disabled cycles: no result, adder inputs held at zero.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h0F, 8'hF0);
            #1;
            check("iso_inputs", {dut.a_iso, dut.b_iso}, 16'h0000);
        end
        drive(1'b1, 8'h0F, 8'hF0);
        drive(1'b1, 8'hAA, 8'h55);
        drive(1'b0, 8'h12, 8'h34);
        drive(1'b0, 8'hFF, 8'hFF);
        drive(1'b0, 8'h12, 8'h34);
        @(negedge clk);
        check("pre_reset_hold", outs(), 16'h00FF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(), 16'h0000);
        m_sum = 0;
        m_cout = 0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'hFF, 8'h01);
        drive(1'b1, 8'h80, 8'h80);
        drive(1'b0, 8'h01, 8'h01);
        for (int i = 0; i < 1000; i++)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 255));
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results never observed, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
